// File: rtl/tpu_host_seq.sv
// Host-side sequencer for the tt_um_tpu pin protocol.
// Takes one 2x2 matrix job (A, B) on a valid/ready port and streams the eight
// operand bytes into the TPU with load strobes. It then waits for the TPU done
// flag, reads the four result bytes back through output_sel, and offers them on
// a valid/ready result port. A WAIT watchdog aborts the job with res_timeout=1.
module tpu_host_seq #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OUT_SETTLE     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_a,
    input  logic [31:0] job_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_timeout,
    output logic        busy,
    output logic [7:0]  tpu_ui,
    output logic [6:0]  tpu_ctrl,
    input  logic [7:0]  tpu_uo,
    input  logic        tpu_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_READ = 3'd3,
        S_RESP = 3'd4
    } state_t;

    // Last WAIT count before abort, and last hold cycle of each read byte.
    localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  SETTLE_LAST = 3'(OUT_SETTLE);

    state_t      state;
    logic [63:0] job_bytes;   // {B3..B0, A3..A0}: byte n is the n-th byte loaded
    logic [2:0]  load_cnt;
    logic [15:0] wait_cnt;
    logic [1:0]  read_idx;
    logic [2:0]  settle_cnt;
    logic [2:0]  load_next;

    // tpu_ctrl word for loading byte n (n<4: A[n], else B[n-4]).
    function automatic logic [6:0] load_ctrl(input logic [2:0] n);
        return {2'b00, 1'b0, n[1:0], n[2], 1'b1};
    endfunction

    // tpu_ctrl word for presenting result byte k on tpu_uo.
    function automatic logic [6:0] read_ctrl(input logic [1:0] k);
        return {k, 1'b1, 2'b00, 1'b0, 1'b0};
    endfunction

    // Index of the operand byte driven after the current one.
    always_comb begin
        load_next = load_cnt + 3'd1;
    end

    // Job sequencer: state, TPU pin drive and result port, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            job_bytes   <= 64'd0;
            load_cnt    <= 3'd0;
            wait_cnt    <= 16'd0;
            read_idx    <= 2'd0;
            settle_cnt  <= 3'd0;
            job_ready   <= 1'b1;
            res_valid   <= 1'b0;
            res_data    <= 32'd0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
            tpu_ui      <= 8'd0;
            tpu_ctrl    <= 7'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid && job_ready) begin
                        job_bytes <= {job_b, job_a};
                        load_cnt  <= 3'd0;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        tpu_ui    <= job_a[7:0];
                        tpu_ctrl  <= load_ctrl(3'd0);
                        state     <= S_LOAD;
                    end else begin
                        job_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_cnt == 3'd7) begin
                        tpu_ui   <= 8'd0;
                        tpu_ctrl <= 7'd0;
                        wait_cnt <= 16'd0;
                        state    <= S_WAIT;
                    end else begin
                        load_cnt <= load_next;
                        tpu_ui   <= job_bytes[{load_next, 3'b000} +: 8];
                        tpu_ctrl <= load_ctrl(load_next);
                    end
                end
                S_WAIT: begin
                    // First WAIT cycle ignores done: it may still be left over from the last job.
                    if ((wait_cnt != 16'd0) && tpu_done) begin
                        read_idx   <= 2'd0;
                        settle_cnt <= 3'd0;
                        tpu_ctrl   <= read_ctrl(2'd0);
                        state      <= S_READ;
                    end else if (wait_cnt == WAIT_LAST) begin
                        res_data    <= 32'd0;
                        res_timeout <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_READ: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        res_data[{read_idx, 3'b000} +: 8] <= tpu_uo;
                        settle_cnt <= 3'd0;
                        if (read_idx == 2'd3) begin
                            tpu_ctrl <= 7'd0;
                            state    <= S_RESP;
                        end else begin
                            read_idx <= read_idx + 2'd1;
                            tpu_ctrl <= read_ctrl(read_idx + 2'd1);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                    end else if (res_ready) begin
                        // job_ready rises with the return to IDLE, one cycle after the handshake.
                        res_valid   <= 1'b0;
                        res_timeout <= 1'b0;
                        busy        <= 1'b0;
                        job_ready   <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        res_valid <= 1'b1;
                    end
                end
                default: begin
                    job_ready   <= 1'b1;
                    res_valid   <= 1'b0;
                    res_timeout <= 1'b0;
                    busy        <= 1'b0;
                    tpu_ui      <= 8'd0;
                    tpu_ctrl    <= 7'd0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
